// File: rtl/traffic_phase_ctrl.sv
// Tick-driven traffic-light phase sequencer for a main road and a side road.
// Optional pedestrian WALK phase is compiled in when PED_WALK_EN is defined.
module traffic_phase_ctrl #(
    parameter int TIMERWIDTH       = 4,
    parameter int MAIN_GREEN_TICKS = 10,
    parameter int SIDE_GREEN_TICKS = 5,
    parameter int YELLOW_TICKS     = 2,
    parameter int ALLRED_TICKS     = 1,
    parameter int WALK_TICKS       = 4
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  tick_in,
    input  logic                  ped_req_in,
    output logic [2:0]            main_light_out,
    output logic [2:0]            side_light_out,
    output logic                  walk_out,
    output logic [2:0]            state_out,
    output logic [TIMERWIDTH-1:0] remaining_out
);

    typedef enum logic [2:0] {
        ALLRED_A    = 3'd0,
        MAIN_GREEN  = 3'd1,
        MAIN_YELLOW = 3'd2,
        ALLRED_B    = 3'd3,
        SIDE_GREEN  = 3'd4,
        SIDE_YELLOW = 3'd5,
        WALK        = 3'd6
    } state_t;

    // A duration of 0 behaves like 1, so the reload value saturates at zero.
    function automatic logic [TIMERWIDTH-1:0] load_val(input int ticks);
        if (ticks <= 1) begin
            return {TIMERWIDTH{1'b0}};
        end else begin
            return TIMERWIDTH'(ticks - 1);
        end
    endfunction

    localparam logic [TIMERWIDTH-1:0] L_ALLRED = load_val(ALLRED_TICKS);
    localparam logic [TIMERWIDTH-1:0] L_MAIN   = load_val(MAIN_GREEN_TICKS);
    localparam logic [TIMERWIDTH-1:0] L_SIDE   = load_val(SIDE_GREEN_TICKS);
    localparam logic [TIMERWIDTH-1:0] L_YELLOW = load_val(YELLOW_TICKS);
    localparam logic [TIMERWIDTH-1:0] L_WALK   = load_val(WALK_TICKS);

    function automatic logic [TIMERWIDTH-1:0] reload(input state_t s);
        case (s)
            MAIN_GREEN:  return L_MAIN;
            MAIN_YELLOW: return L_YELLOW;
            SIDE_GREEN:  return L_SIDE;
            SIDE_YELLOW: return L_YELLOW;
            WALK:        return L_WALK;
            default:     return L_ALLRED;
        endcase
    endfunction

    // Packed as {main[2:0], side[2:0], walk}; lamps are {red, yellow, green}.
    function automatic logic [6:0] decode(input state_t s);
        case (s)
            MAIN_GREEN:  return {3'b001, 3'b100, 1'b0};
            MAIN_YELLOW: return {3'b010, 3'b100, 1'b0};
            SIDE_GREEN:  return {3'b100, 3'b001, 1'b0};
            SIDE_YELLOW: return {3'b100, 3'b010, 1'b0};
            WALK:        return {3'b100, 3'b100, 1'b1};
            default:     return {3'b100, 3'b100, 1'b0};
        endcase
    endfunction

    state_t                  r_state;
    logic [TIMERWIDTH-1:0]   r_timer;
    logic [6:0]              r_lights;
    state_t                  w_state_nxt;
    state_t                  w_seq_nxt;
    logic [TIMERWIDTH-1:0]   w_timer_nxt;
    logic                    w_ped_eff;
    logic                    w_illegal;

`ifdef PED_WALK_EN
    logic r_pend;
    logic w_enter_walk;

    assign w_ped_eff    = r_pend | ped_req_in;
    assign w_enter_walk = (w_state_nxt == WALK) && (r_state != WALK);

    // Pending request latch; a request seen while entering WALK is consumed by it.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_pend <= 1'b0;
        end else if (w_enter_walk) begin
            r_pend <= 1'b0;
        end else begin
            r_pend <= w_ped_eff;
        end
    end

    assign walk_out = r_lights[0];
`else
    logic [1:0] w_unused;

    assign w_ped_eff = 1'b0;
    assign w_unused  = {ped_req_in, r_lights[0]};
    assign walk_out  = 1'b0;
`endif

    // Phase sequencing and down-counter next-state logic.
    always_comb begin
        case (r_state)
            ALLRED_A:    w_seq_nxt = MAIN_GREEN;
            MAIN_GREEN:  w_seq_nxt = MAIN_YELLOW;
            MAIN_YELLOW: w_seq_nxt = ALLRED_B;
            ALLRED_B:    w_seq_nxt = w_ped_eff ? WALK : SIDE_GREEN;
            SIDE_GREEN:  w_seq_nxt = SIDE_YELLOW;
            SIDE_YELLOW: w_seq_nxt = ALLRED_A;
            WALK:        w_seq_nxt = SIDE_GREEN;
            default:     w_seq_nxt = ALLRED_A;
        endcase
        w_illegal   = (3'(r_state) == 3'd7);
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        if (w_illegal) begin
            w_state_nxt = ALLRED_A;
            w_timer_nxt = L_ALLRED;
        end else if (tick_in && (r_timer != {TIMERWIDTH{1'b0}})) begin
            w_timer_nxt = r_timer - {{(TIMERWIDTH-1){1'b0}}, 1'b1};
        end else if (tick_in) begin
            w_state_nxt = w_seq_nxt;
            w_timer_nxt = reload(w_seq_nxt);
        end else begin
            w_state_nxt = r_state;
        end
    end

    // State, timer and lamp registers; lamps follow the state they accompany.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state  <= ALLRED_A;
            r_timer  <= L_ALLRED;
            r_lights <= decode(ALLRED_A);
        end else begin
            r_state  <= w_state_nxt;
            r_timer  <= w_timer_nxt;
            r_lights <= decode(w_state_nxt);
        end
    end

    assign main_light_out = r_lights[6:4];
    assign side_light_out = r_lights[3:1];
    assign state_out      = 3'(r_state);
    assign remaining_out  = r_timer;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Scoreboard bench for traffic_phase_ctrl: a duration-table model predicts every
// cycle's outputs, and each scenario task also checks its own landmark values.
module tb_traffic_phase_ctrl;

    localparam int TW = 4;
    localparam int DUR_MG = 10, DUR_SG = 5, DUR_Y = 2, DUR_AR = 1, DUR_W = 4;
`ifdef PED_WALK_EN
    localparam bit PED = 1'b1;
`else
    localparam bit PED = 1'b0;
`endif

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b1;
    logic          tick_in = 1'b0;
    logic          ped_req_in = 1'b0;
    logic [2:0]    main_light_out, side_light_out, state_out;
    logic          walk_out;
    logic [TW-1:0] remaining_out;

    traffic_phase_ctrl #(
        .TIMERWIDTH(TW), .MAIN_GREEN_TICKS(DUR_MG), .SIDE_GREEN_TICKS(DUR_SG),
        .YELLOW_TICKS(DUR_Y), .ALLRED_TICKS(DUR_AR), .WALK_TICKS(DUR_W)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .tick_in(tick_in), .ped_req_in(ped_req_in),
        .main_light_out(main_light_out), .side_light_out(side_light_out),
        .walk_out(walk_out), .state_out(state_out), .remaining_out(remaining_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [2:0]    st;
        logic [2:0]    ml;
        logic [2:0]    sl;
        logic          wk;
        logic [TW-1:0] rem;
    } obs_t;

    obs_t exp_q[$];
    obs_t act_q[$];
    int   n_pass = 0;
    int   n_total = 0;

    int   m_state = 0;
    int   m_cnt   = 0;
    bit   m_pend  = 1'b0;

    function automatic int dur(input int s);
        case (s)
            1: return DUR_MG;
            2: return DUR_Y;
            4: return DUR_SG;
            5: return DUR_Y;
            6: return DUR_W;
            default: return DUR_AR;
        endcase
    endfunction

    function automatic obs_t model_out();
        obs_t o;
        o.st  = 3'(m_state);
        o.ml  = (m_state == 1) ? 3'b001 : (m_state == 2) ? 3'b010 : 3'b100;
        o.sl  = (m_state == 4) ? 3'b001 : (m_state == 5) ? 3'b010 : 3'b100;
        o.wk  = (m_state == 6);
        o.rem = TW'(dur(m_state) - 1 - m_cnt);
        return o;
    endfunction

    task automatic model_step(input bit rst, input bit tick, input bit ped);
        bit eff;
        int nxt;
        if (rst) begin
            m_state = 0; m_cnt = 0; m_pend = 1'b0;
        end else begin
            eff    = PED && (m_pend || ped);
            m_pend = eff;
            if (tick && (m_cnt == dur(m_state) - 1)) begin
                case (m_state)
                    3: nxt = eff ? 6 : 4;
                    5: nxt = 0;
                    6: nxt = 4;
                    default: nxt = m_state + 1;
                endcase
                if (nxt == 6) m_pend = 1'b0;
                m_state = nxt;
                m_cnt   = 0;
            end else if (tick) begin
                m_cnt++;
            end
        end
    endtask

    // Apply inputs for one clock, predict the result, capture what the DUT shows.
    task automatic drive(input bit rst, input bit tick, input bit ped);
        rst_in = rst; tick_in = tick; ped_req_in = ped;
        model_step(rst, tick, ped);
        exp_q.push_back(model_out());
        @(negedge clk_in);
        act_q.push_back({state_out, main_light_out, side_light_out, walk_out, remaining_out});
    endtask

    task automatic test_reset();
        obs_t e, a;
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        n_total++;
        if ({state_out, main_light_out, side_light_out, walk_out, remaining_out} !==
            {3'd0, 3'b100, 3'b100, 1'b0, 4'd0})
            $display("FAIL reset_state got=%h/%b/%b/%b/%0d want=0/100/100/0/0",
                     state_out, main_light_out, side_light_out, walk_out, remaining_out);
        else n_pass++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n_total++;
            if (a !== e) $display("FAIL sb_reset got=%h want=%h", a, e); else n_pass++;
        end
    endtask

    task automatic test_full_loop();
        obs_t e, a;
        int ticks = 0;
        int first_state = -1;
        for (int i = 0; i < 400; i++) begin
            drive(1'b0, (i % 4) == 3, 1'b0);
            if ((i % 4) == 3) begin
                ticks++;
                if (ticks == 1) first_state = state_out;
                if (state_out == 3'd0) break;
            end
        end
        n_total++;
        if (first_state != 1) $display("FAIL loop_first_tick got=%0d want=1", first_state);
        else n_pass++;
        n_total++;
        if (ticks != 21 || state_out !== 3'd0)
            $display("FAIL loop_length got=%0d ticks state=%0d want=21 ticks state=0", ticks, state_out);
        else n_pass++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n_total++;
            if (a !== e) $display("FAIL sb_loop got=%h want=%h", a, e); else n_pass++;
        end
    endtask

    task automatic test_freeze();
        obs_t e, a;
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 100; i++) drive(1'b0, 1'b0, 1'b0);
        n_total++;
        if (state_out !== 3'd1 || remaining_out !== 4'd7)
            $display("FAIL freeze got=%0d/%0d want=1/7", state_out, remaining_out);
        else n_pass++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n_total++;
            if (a !== e) $display("FAIL sb_freeze got=%h want=%h", a, e); else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        obs_t e, a;
        for (int i = 0; i < 60; i++) begin
            if (state_out == 3'd4 && remaining_out == 4'd3) break;
            drive(1'b0, 1'b1, 1'b0);
        end
        n_total++;
        if (state_out !== 3'd4 || remaining_out !== 4'd3)
            $display("FAIL reach_side_green got=%0d/%0d want=4/3", state_out, remaining_out);
        else n_pass++;
        drive(1'b1, 1'b1, 1'b0);
        n_total++;
        if ({state_out, main_light_out, side_light_out, remaining_out} !== {3'd0, 3'b100, 3'b100, 4'd0})
            $display("FAIL reset_mid got=%0d/%b/%b/%0d want=0/100/100/0",
                     state_out, main_light_out, side_light_out, remaining_out);
        else n_pass++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n_total++;
            if (a !== e) $display("FAIL sb_reset_mid got=%h want=%h", a, e); else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        obs_t e, a;
        int n_mg = 0;
        drive(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 30; i++) begin
            if (state_out != 3'd1) break;
            n_mg++;
            drive(1'b0, 1'b1, 1'b0);
        end
        n_total++;
        if (n_mg != 10 || state_out !== 3'd2 || remaining_out !== 4'd1)
            $display("FAIL back_to_back got=%0d cycles next=%0d/%0d want=10 cycles next=2/1",
                     n_mg, state_out, remaining_out);
        else n_pass++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n_total++;
            if (a !== e) $display("FAIL sb_back_to_back got=%h want=%h", a, e); else n_pass++;
        end
    endtask

`ifdef PED_WALK_EN
    // Run ticks until state 0 comes back; returns the number of WALK cycles seen.
    task automatic run_loop(output int walks, input int ped_at);
        walks = 0;
        for (int k = 0; k < 60; k++) begin
            drive(1'b0, 1'b1, (k == ped_at));
            if (walk_out === 1'b1) walks++;
            if (state_out == 3'd0) break;
        end
    endtask

    task automatic test_ped_walk();
        obs_t e, a;
        int w1, w2, w3, w4;
        drive(1'b1, 1'b0, 1'b0);
        run_loop(w1, 3);
        run_loop(w2, -1);
        for (int k = 0; k < 60 && state_out != 3'd3; k++) drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b1);
        run_loop(w3, -1);
        run_loop(w4, -1);
        n_total++;
        if (w1 != 4 || w2 != 0) $display("FAIL ped_walk got=%0d,%0d want=4,0", w1, w2);
        else n_pass++;
        n_total++;
        if (w3 != 3 || w4 != 0) $display("FAIL ped_absorb got=%0d,%0d want=3,0", w3, w4);
        else n_pass++;
        for (int k = 0; k < 60 && state_out != 3'd6; k++) drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        run_loop(w1, 0);
        run_loop(w2, -1);
        n_total++;
        if (w2 != 4 || state_out !== 3'd0) $display("FAIL ped_rearm got=%0d want=4", w2);
        else n_pass++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n_total++;
            if (a !== e) $display("FAIL sb_ped got=%h want=%h", a, e); else n_pass++;
        end
    endtask
`else
    task automatic test_ped_ignored();
        obs_t e, a;
        int walks = 0;
        int sixes = 0;
        drive(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 50; k++) begin
            drive(1'b0, 1'b1, 1'($urandom_range(0, 1)));
            if (walk_out !== 1'b0) walks++;
            if (state_out == 3'd6) sixes++;
        end
        n_total++;
        if (walks != 0 || sixes != 0) $display("FAIL ped_ignored got=%0d,%0d want=0,0", walks, sixes);
        else n_pass++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n_total++;
            if (a !== e) $display("FAIL sb_ped_ignored got=%h want=%h", a, e); else n_pass++;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_full_loop();
        test_freeze();
        test_reset_mid();
        test_back_to_back();
`ifdef PED_WALK_EN
        test_ped_walk();
`else
        test_ped_ignored();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
